fwrisc_decode_stim_seq: RTL and testbench

Parametrised instruction-stimulus sequencer for decode-stage formal and simulation benches. It replays a programmed table of up to `DEPTH` instructions (32-bit or compressed) into the decoder's fetch interface over the `fetch_valid`/`decode_ready` handshake. Gap cycles, looping and a stall watchdog are configurable. It sits in the bench's stimulus slot in place of single-instruction drivers, in front of the decoder under test.

---
 rtl/fwrisc_decode_stim_pkg.sv | 23 ++
 rtl/fwrisc_decode_stim_table.sv | 27 ++
 rtl/fwrisc_decode_stim_seq.sv | 168 ++++++++++++++++
 tb/tb_fwrisc_decode_stim_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_decode_stim_pkg.sv
// Shared types and constants for the decode-stage instruction stimulus sequencer.
package fwrisc_decode_stim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } stim_state_e;

   typedef struct packed {
      logic        c;
      logic [31:0] instr;
   } stim_entry_t;

   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_OPIMM = 7'h13;

   // Compressed entries only carry 16 meaningful bits; the upper half is forced to zero.
   function automatic logic [31:0] entry_word(stim_entry_t e);
      return e.c ? {16'h0000, e.instr[15:0]} : e.instr;
   endfunction

endpackage

// File: rtl/fwrisc_decode_stim_table.sv
// Sequence table: DEPTH entries of {c, instr}, one synchronous write port and
// one combinational read port. Not reset, so a programmed table survives a
// sequencer reset.
module fwrisc_decode_stim_table
   import fwrisc_decode_stim_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [32:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [32:0]   rdata
);

   stim_entry_t mem [DEPTH];

   // single write port
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fwrisc_decode_stim_seq.sv
// Instruction-stimulus sequencer: replays the programmed table into the
// decoder fetch interface over the fetch_valid/decode_ready handshake, with
// optional inter-instruction gaps, looping and a stall watchdog.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | no run active; table writable, waiting for start
//   S_PRESENT  | fetch_valid high, current entry held on instr/instr_c
//   S_GAP      | between an accept and the next entry, fetch_valid low
module fwrisc_decode_stim_seq
   import fwrisc_decode_stim_pkg::*;
#(
   parameter  int DEPTH   = 8,
   parameter  int GAP_W   = 4,
   parameter  int CNT_W   = 16,
   parameter  int TIMEOUT = 64,
   localparam int AW      = $clog2(DEPTH),
   localparam int LW      = AW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [31:0]      cfg_instr,
   input  logic             cfg_c,
   input  logic [LW-1:0]    cfg_len,
   input  logic [GAP_W-1:0] cfg_gap,
   input  logic             cfg_loop,
   input  logic             start,
   input  logic             decode_ready,
   output logic             fetch_valid,
   output logic [31:0]      instr,
   output logic             instr_c,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] issued,
   output logic             timeout
);

   localparam logic [1:0] S_IDLE    = ST_IDLE;
   localparam logic [1:0] S_PRESENT = ST_PRESENT;
   localparam logic [1:0] S_GAP     = ST_GAP;

   // Watchdog is a down-counter loaded with TIMEOUT-1 on entry to S_PRESENT;
   // reaching zero without an accept means TIMEOUT presented cycles elapsed.
   localparam int              WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [AW-1:0]    idx;
   logic [AW-1:0]    idx_nxt;
   logic [AW-1:0]    rd_addr;
   logic [LW-1:0]    len_q;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt;
   logic             loop_q;
   logic [WD_W-1:0]  wd_cnt;
   logic [32:0]      rd_data;
   stim_entry_t      rd_entry;
   logic             accept;
   logic             last;

   fwrisc_decode_stim_table #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_table (
      .clock (clock),
      .we    (cfg_we && (state == S_IDLE)),
      .waddr (cfg_addr),
      .wdata ({cfg_c, cfg_instr}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign rd_entry    = rd_data;
   assign fetch_valid = (state == S_PRESENT);
   assign busy        = (state != S_IDLE);
   assign accept      = fetch_valid && decode_ready;
   assign last        = (({1'b0, idx} + LW'(1)) == len_q);
   assign idx_nxt     = last ? '0 : idx + AW'(1);

   // read address: entry 0 for a start, the following entry while presenting
   // (gap=0 back-to-back), the already-advanced index while in a gap
   always_comb begin
      rd_addr = idx;
      case (state)
         S_IDLE:    rd_addr = '0;
         S_PRESENT: rd_addr = idx_nxt;
         default:   rd_addr = idx;
      endcase
   end

   // sequencing FSM with gap counter, watchdog and issue counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         idx     <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         loop_q  <= 1'b0;
         wd_cnt  <= '0;
         instr   <= '0;
         instr_c <= 1'b0;
         done    <= 1'b0;
         issued  <= '0;
         timeout <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state   <= S_PRESENT;
                     idx     <= '0;
                     len_q   <= (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
                     gap_q   <= cfg_gap;
                     loop_q  <= cfg_loop;
                     issued  <= '0;
                     timeout <= 1'b0;
                     wd_cnt  <= WD_LOAD;
                     instr   <= entry_word(rd_entry);
                     instr_c <= rd_entry.c;
                  end
               end
            end
            S_PRESENT: begin
               if (accept) begin
                  if (issued != '1) issued <= issued + CNT_W'(1);
                  if (last && !loop_q) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx_nxt;
                     if (gap_q == '0) begin
                        instr   <= entry_word(rd_entry);
                        instr_c <= rd_entry.c;
                        wd_cnt  <= WD_LOAD;
                     end else begin
                        state   <= S_GAP;
                        gap_cnt <= gap_q - GAP_W'(1);
                     end
                  end
               end else if (wd_cnt == '0) begin
                  timeout <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt - WD_W'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state   <= S_PRESENT;
                  instr   <= entry_word(rd_entry);
                  instr_c <= rd_entry.c;
                  wd_cnt  <= WD_LOAD;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fwrisc_decode_stim_seq.sv
// Bench for fwrisc_decode_stim_seq: directed runs, a behavioural model checked
// on every falling edge, and literal expectations at key points.
module tb_fwrisc_decode_stim_seq;
   import fwrisc_decode_stim_pkg::*;

   localparam int DEPTH   = 8;
   localparam int GAP_W   = 4;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 64;
   localparam int AW      = 3;
   localparam int LW      = 4;

   localparam logic [31:0] LUI_X5 = {20'h12345, 5'd5, OP_LUI};
   localparam logic [31:0] ADDI1  = {12'd1, 5'd0, 3'd0, 5'd1, OP_OPIMM};

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_we = 1'b0;
   logic [AW-1:0]    cfg_addr = '0;
   logic [31:0]      cfg_instr = '0;
   logic             cfg_c = 1'b0;
   logic [LW-1:0]    cfg_len = '0;
   logic [GAP_W-1:0] cfg_gap = '0;
   logic             cfg_loop = 1'b0;
   logic             start = 1'b0;
   logic             decode_ready = 1'b0;
   logic             fetch_valid;
   logic [31:0]      instr;
   logic             instr_c;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] issued;
   logic             timeout;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   fwrisc_decode_stim_seq #(
      .DEPTH   (DEPTH),
      .GAP_W   (GAP_W),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_instr    (cfg_instr),
      .cfg_c        (cfg_c),
      .cfg_len      (cfg_len),
      .cfg_gap      (cfg_gap),
      .cfg_loop     (cfg_loop),
      .start        (start),
      .decode_ready (decode_ready),
      .fetch_valid  (fetch_valid),
      .instr        (instr),
      .instr_c      (instr_c),
      .busy         (busy),
      .done         (done),
      .issued       (issued),
      .timeout      (timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [32:0] m_tab [DEPTH];
   bit          mon_en     = 0;
   bit          m_busy     = 0;
   bit          m_fv       = 0;
   bit          m_done     = 0;
   bit          m_timeout  = 0;
   bit          m_loop     = 0;
   bit          m_c        = 0;
   int          m_issued   = 0;
   int          m_len      = 0;
   int          m_gap      = 0;
   int          m_pos      = 0;
   int          m_gap_left = 0;
   int          m_stall    = 0;
   logic [31:0] m_word     = '0;

   function automatic logic [31:0] expand(input logic [32:0] e);
      return e[32] ? {16'h0000, e[15:0]} : e[31:0];
   endfunction

   // Outputs are checked on the falling edge; the inputs seen here are the
   // ones the next rising edge will act on, so the model then steps forward.
   always @(negedge clock) begin
      if (mon_en) begin
         check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
         check("busy", {31'b0, busy}, {31'b0, m_busy});
         check("done", {31'b0, done}, {31'b0, m_done});
         check("timeout", {31'b0, timeout}, {31'b0, m_timeout});
         check("issued", {16'b0, issued}, m_issued);
         if (m_fv) begin
            check("instr", instr, m_word);
            check("instr_c", {31'b0, instr_c}, {31'b0, m_c});
         end
         if (reset) begin
            m_busy = 0; m_fv = 0; m_done = 0; m_timeout = 0; m_issued = 0;
         end else begin
            m_done = 0;
            if (!m_busy) begin
               if (start) begin
                  if (cfg_len == 0) begin
                     m_done = 1;
                  end else begin
                     m_busy = 1; m_fv = 1; m_pos = 0; m_issued = 0; m_timeout = 0; m_stall = 0;
                     m_len  = (cfg_len > DEPTH) ? DEPTH : int'(cfg_len);
                     m_gap  = int'(cfg_gap);
                     m_loop = cfg_loop;
                     m_word = expand(m_tab[0]);
                     m_c    = m_tab[0][32];
                  end
               end
               if (cfg_we) m_tab[cfg_addr] = {cfg_c, cfg_instr};
            end else if (m_fv) begin
               if (decode_ready) begin
                  if (m_issued < 65535) m_issued++;
                  m_stall = 0;
                  if (m_pos == m_len - 1 && !m_loop) begin
                     m_busy = 0; m_fv = 0; m_done = 1;
                  end else begin
                     m_pos = (m_pos + 1) % m_len;
                     if (m_gap == 0) begin
                        m_word = expand(m_tab[m_pos]);
                        m_c    = m_tab[m_pos][32];
                     end else begin
                        m_fv = 0;
                        m_gap_left = m_gap;
                     end
                  end
               end else begin
                  m_stall++;
                  if (m_stall == TIMEOUT) begin
                     m_timeout = 1; m_fv = 0; m_busy = 0;
                  end
               end
            end else begin
               m_gap_left--;
               if (m_gap_left == 0) begin
                  m_fv = 1; m_stall = 0;
                  m_word = expand(m_tab[m_pos]);
                  m_c    = m_tab[m_pos][32];
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_entry(input int addr, input logic [31:0] w, input logic c);
      cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_instr = w; cfg_c = c;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_start(input int len, input int gap, input logic loop);
      cfg_len = LW'(len); cfg_gap = GAP_W'(gap); cfg_loop = loop;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_w [3];
      logic        exp_c [3];
      int          vcnt;
      int          lcnt;
      bit          seen_done;

      for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
      tick();
      mon_en = 1;
      tick();
      reset = 1'b0;
      tick();

      // single entry with stalled ready
      write_entry(0, LUI_X5, 1'b0);
      decode_ready = 1'b0;
      do_start(1, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("t1_hold_valid", {31'b0, fetch_valid}, 32'd1);
         check("t1_hold_instr", instr, 32'h123452B7);
         tick();
      end
      decode_ready = 1'b1;
      tick();
      check("t1_done", {31'b0, done}, 32'd1);
      check("t1_issued", {16'b0, issued}, 32'd1);
      check("t1_valid_low", {31'b0, fetch_valid}, 32'd0);
      decode_ready = 1'b0;
      tick();
      check("t1_done_pulse", {31'b0, done}, 32'd0);

      // three entries back to back, third compressed with junk upper bits
      write_entry(1, ADDI1, 1'b0);
      write_entry(2, 32'hABCD0001, 1'b1);
      exp_w[0] = 32'h123452B7; exp_c[0] = 1'b0;
      exp_w[1] = 32'h00100093; exp_c[1] = 1'b0;
      exp_w[2] = 32'h00000001; exp_c[2] = 1'b1;
      decode_ready = 1'b1;
      do_start(3, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("t2_instr", instr, exp_w[i]);
         check("t2_instr_c", {31'b0, instr_c}, {31'b0, exp_c[i]});
         tick();
      end
      check("t2_done", {31'b0, done}, 32'd1);
      check("t2_issued", {16'b0, issued}, 32'd3);
      tick();

      // same sequence with gap=2
      do_start(3, 2, 1'b0);
      vcnt = 0; lcnt = 0; seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen_done = 1;
            break;
         end
         if (fetch_valid) vcnt++; else lcnt++;
         tick();
      end
      check("t3_done_seen", {31'b0, seen_done}, 32'd1);
      check("t3_valid_cycles", vcnt, 32'd3);
      check("t3_gap_cycles", lcnt, 32'd4);
      tick();

      // looping over two entries
      do_start(2, 0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         check("t4_alt_instr", instr, (i % 2 == 0) ? 32'h123452B7 : 32'h00100093);
         tick();
      end
      check("t4_issued", {16'b0, issued}, 32'd10);
      check("t4_still_busy", {31'b0, busy}, 32'd1);

      // stall until the watchdog trips
      decode_ready = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (!fetch_valid) break;
         vcnt++;
         tick();
      end
      check("t5_stall_cycles", vcnt, 32'd64);
      check("t5_timeout", {31'b0, timeout}, 32'd1);
      check("t5_idle", {31'b0, busy}, 32'd0);
      tick();
      do_start(1, 0, 1'b0);
      check("t5_timeout_cleared", {31'b0, timeout}, 32'd0);
      decode_ready = 1'b1;
      tick();
      check("t5_done", {31'b0, done}, 32'd1);
      decode_ready = 1'b0;
      tick();

      // table write while busy is dropped
      do_start(1, 0, 1'b0);
      write_entry(0, 32'hDEADBEEF, 1'b1);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      tick();
      do_start(1, 0, 1'b0);
      check("t6_table_kept", instr, 32'h123452B7);
      check("t6_table_kept_c", {31'b0, instr_c}, 32'd0);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      tick();

      // zero-length run
      do_start(0, 0, 1'b0);
      check("t7_len0_done", {31'b0, done}, 32'd1);
      check("t7_len0_valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check("t7_len0_pulse", {31'b0, done}, 32'd0);

      // reset mid-run
      decode_ready = 1'b1;
      do_start(3, 1, 1'b1);
      tick();
      tick();
      check("t8_busy_before", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      check("t8_valid", {31'b0, fetch_valid}, 32'd0);
      check("t8_busy", {31'b0, busy}, 32'd0);
      check("t8_issued", {16'b0, issued}, 32'd0);
      check("t8_instr", instr, 32'd0);
      check("t8_instr_c", {31'b0, instr_c}, 32'd0);
      check("t8_done", {31'b0, done}, 32'd0);
      reset = 1'b0;
      decode_ready = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
